// File: rtl/alu_addsub_seq.sv
// ---------------------------------------------------------------------------
// alu_addsub_seq
//
// Multi-cycle add/subtract unit for the ALU datapath. The carry chain is
// broken into WIDTH/SLICE slices and one slice is added per clock, so the
// critical path is a single SLICE-bit ripple regardless of WIDTH.
//
// Arithmetic:
//    add : out = a + b + cin
//    sub : out = a - b - cin, formed as a + ~b + !cin
//    results wrap modulo 2^WIDTH
//
// Parameters:
//    WIDTH    operand/result width, must be a multiple of SLICE
//    SLICE    bits added per clock, 1 <= SLICE <= WIDTH
//
// Ports:
//    clk       clock, all state changes on the rising edge
//    rst       asynchronous active-high reset, aborts any operation
//    start     request, only looked at while idle
//    sub       0 = add, 1 = subtract (sampled with start)
//    cin       carry-in for add, borrow-in for sub (sampled with start)
//    a, b      operands (sampled with start)
//    busy      high while an operation is in flight
//    done      one-cycle pulse, result and flags valid from this cycle
//    out       result register
//    carry     raw carry out of the MSB (for sub: 1 = no borrow)
//    overflow  signed overflow (carry into MSB xor carry out of MSB)
//    zero      high when out == 0
//
// Timing: a start accepted on edge T keeps busy high through edge T+NS-1;
// the last slice is added on edge T+NS, which also loads out and the flags
// and raises done for one cycle. The unit is idle again in the done cycle,
// so a start held there is accepted on the following edge.
// ---------------------------------------------------------------------------
module alu_addsub_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   // Number of slices and the widths needed to index them.
   localparam int NS = WIDTH / SLICE;
   localparam int KW = (NS > 1) ? $clog2(NS) : 1;
   localparam int PW = $clog2(WIDTH) + 1;

   localparam logic [KW-1:0]    K_LAST     = KW'(NS - 1);
   localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

   // Controller states.
   localparam logic IDLE = 1'b0;
   localparam logic RUN  = 1'b1;

   logic             state;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             chain_c;
   logic [WIDTH-1:0] shadow;

   logic [PW-1:0]    pos;
   logic [SLICE-1:0] slice_a;
   logic [SLICE-1:0] slice_b;
   logic [SLICE:0]   slice_sum;
   logic [WIDTH-1:0] shadow_next;
   logic             last_slice;
   logic             msb_carry_in;
   logic             accept;

   assign accept = (state == IDLE) && start;

   // Slice datapath. The active slice is selected by shifting the operand
   // registers down by k*SLICE rather than with an indexed part-select, and
   // the slice sum is merged back into the shadow register with a mask.
   // The carry into the MSB is recovered from the MSB sum bit: for a full
   // adder sum = a ^ b ^ cin, so cin = sum ^ a ^ b. This works for every
   // SLICE including SLICE = 1, where the MSB is the whole slice.
   always_comb begin
      pos          = PW'(k) * PW'(SLICE);
      slice_a      = SLICE'(op_a >> pos);
      slice_b      = SLICE'(op_b >> pos);
      slice_sum    = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, chain_c};
      shadow_next  = (shadow & ~(SLICE_MASK << pos))
                   | (WIDTH'(slice_sum[SLICE-1:0]) << pos);
      last_slice   = (k == K_LAST);
      msb_carry_in = slice_sum[SLICE-1] ^ slice_a[SLICE-1] ^ slice_b[SLICE-1];
   end

   // Controller: IDLE accepts a request, RUN walks k over the slices and
   // returns to IDLE on the edge that processes the last slice. busy and
   // done are registered here so neither depends on the inputs
   // combinationally. A start seen during RUN is simply not looked at.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         k     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= RUN;
                  k     <= '0;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (last_slice) begin
                  state <= IDLE;
                  k     <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  k <= k + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               k     <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Operand capture and carry chain. Subtraction is folded into addition
   // here: B is inverted and the borrow-in becomes an inverted carry-in, so
   // the slice adder never needs to know which operation is running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a    <= '0;
         op_b    <= '0;
         chain_c <= 1'b0;
      end else if (accept) begin
         op_a    <= a;
         op_b    <= sub ? ~b : b;
         chain_c <= sub ? ~cin : cin;
      end else if (state == RUN) begin
         chain_c <= slice_sum[SLICE];
      end
   end

   // Shadow register collecting slice sums while the operation runs. Its
   // contents are only meaningful on the completion edge, where they are
   // copied into out together with the last slice.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= '0;
      end else if (state == RUN) begin
         shadow <= shadow_next;
      end
   end

   // Architectural result and flags. These hold the previous result for
   // the whole of RUN and change only on the edge that finishes the last
   // slice, so a consumer may read them at any time outside of done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else if ((state == RUN) && last_slice) begin
         out      <= shadow_next;
         carry    <= slice_sum[SLICE];
         overflow <= msb_carry_in ^ slice_sum[SLICE];
         zero     <= (shadow_next == '0);
      end
   end

endmodule

// File: tb/tb_alu_addsub_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_addsub_seq
//
// Bench for alu_addsub_seq. Three instances share one stimulus stream:
//    inst0  WIDTH=16 SLICE=4  (latency 4)
//    inst1  WIDTH=8  SLICE=8  (latency 1)
//    inst2  WIDTH=8  SLICE=1  (latency 8)
// The 8-bit instances see the low byte of the operands. For every start an
// instance is expected to accept, the expected result and completion edge
// are pushed into that instance's queue; a monitor pops on done.
// ---------------------------------------------------------------------------
module tb_alu_addsub_seq;

   typedef struct {
      logic [18:0] res;
      int          done_edge;
   } exp_t;

   localparam int NSV [3] = '{4, 1, 8};
   localparam int WV  [3] = '{16, 8, 8};

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        start = 1'b0;
   logic        sub   = 1'b0;
   logic        cin   = 1'b0;
   logic [15:0] a     = '0;
   logic [15:0] b     = '0;

   logic        busy0, done0, carry0, ovf0, zero0;
   logic [15:0] out0;
   logic        busy1, done1, carry1, ovf1, zero1;
   logic [7:0]  out1;
   logic        busy2, done2, carry2, ovf2, zero2;
   logic [7:0]  out2;

   logic [2:0]  busy_v;
   logic [2:0]  done_v;
   logic [18:0] res_v [3];

   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   int          idle_edge [3];
   logic [18:0] hold [3];
   int          busy_run [3];
   exp_t        q0 [$];
   exp_t        q1 [$];
   exp_t        q2 [$];

   alu_addsub_seq #(.WIDTH(16), .SLICE(4)) dut0 (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
      .a(a), .b(b), .busy(busy0), .done(done0), .out(out0),
      .carry(carry0), .overflow(ovf0), .zero(zero0));

   alu_addsub_seq #(.WIDTH(8), .SLICE(8)) dut1 (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
      .a(a[7:0]), .b(b[7:0]), .busy(busy1), .done(done1), .out(out1),
      .carry(carry1), .overflow(ovf1), .zero(zero1));

   alu_addsub_seq #(.WIDTH(8), .SLICE(1)) dut2 (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
      .a(a[7:0]), .b(b[7:0]), .busy(busy2), .done(done2), .out(out2),
      .carry(carry2), .overflow(ovf2), .zero(zero2));

   always #5 clk = ~clk;

   // Edge counter: after a rising edge it holds that edge's number.
   always @(posedge clk) cyc <= cyc + 1;

   // Gather the instance outputs into indexable form for the monitor.
   always_comb begin
      busy_v   = {busy2, busy1, busy0};
      done_v   = {done2, done1, done0};
      res_v[0] = {out0, carry0, ovf0, zero0};
      res_v[1] = {8'h00, out1, carry1, ovf1, zero1};
      res_v[2] = {8'h00, out2, carry2, ovf2, zero2};
   end

   // Reference model from plain integer arithmetic. Packed as
   // {out[15:0], carry, overflow, zero}. Overflow is judged by whether the
   // true signed result falls outside the w-bit signed range.
   function automatic logic [18:0] refModel(input logic [15:0] va, input logic [15:0] vb,
                                            input logic vsub, input logic vcin, input int w);
      longint mask, ua, ub, full, res, cy, lim, sa, sb, sres;
      logic   ovf;
      mask = (longint'(1) << w) - 1;
      ua   = longint'(va) & mask;
      ub   = longint'(vb) & mask;
      if (vsub) full = ua + ((~ub) & mask) + longint'(!vcin);
      else      full = ua + ub + longint'(vcin);
      res  = full & mask;
      cy   = (full >> w) & 1;
      lim  = longint'(1) << (w - 1);
      sa   = (ua >= lim) ? ua - 2 * lim : ua;
      sb   = (ub >= lim) ? ub - 2 * lim : ub;
      sres = vsub ? sa - sb - longint'(vcin) : sa + sb + longint'(vcin);
      ovf  = (sres >= lim) || (sres < -lim);
      return {res[15:0], cy[0], ovf, (res == 0)};
   endfunction

   task automatic checkOutput(input string name, input int inst,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s inst%0d: got %h expected %h (t=%0t)", name, inst, act, exp, $time);
      end
   endtask

   task automatic pushExp(input int i, input exp_t e);
      case (i)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic popExp(input int i, output exp_t e, output bit ok);
      ok = 1'b0;
      e  = '{res: '0, done_edge: 0};
      case (i)
         0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
         1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
      endcase
   endtask

   // Advance one edge and record which instances accept the inputs that
   // were present on it. An instance is idle from one edge after its done.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         if (start && !rst && cyc >= idle_edge[i]) begin
            e.res       = refModel(a, b, sub, cin, WV[i]);
            e.done_edge = cyc + NSV[i];
            pushExp(i, e);
            idle_edge[i] = cyc + NSV[i] + 1;
         end
      end
   endtask

   function automatic bit allIdleNext();
      bit r = 1'b1;
      for (int i = 0; i < 3; i++)
         if (cyc + 1 < idle_edge[i]) r = 1'b0;
      return r;
   endfunction

   // One request that every instance accepts.
   task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                                input logic vsub, input logic vcin);
      for (int n = 0; n < 20 && !allIdleNext(); n++) tick();
      a = va; b = vb; sub = vsub; cin = vcin; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic randomOperands();
      a   = 16'($urandom);
      b   = 16'($urandom);
      sub = 1'($urandom);
      cin = 1'($urandom);
   endtask

   // Monitor: on done, pop and compare the result, the completion edge and
   // the length of the preceding busy window; otherwise the outputs must
   // hold the last completed result.
   always @(negedge clk) begin
      exp_t e;
      bit   ok;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            hold[i]     = '0;
            busy_run[i] = 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (done_v[i]) begin
               popExp(i, e, ok);
               if (!ok) begin
                  checkOutput("unexpected_done", i, 32'(done_v[i]), 32'd0);
               end else begin
                  checkOutput("result", i, 32'(res_v[i]), 32'(e.res));
                  checkOutput("done_edge", i, cyc, e.done_edge);
                  checkOutput("busy_in_done", i, 32'(busy_v[i]), 32'd0);
                  checkOutput("busy_len", i, busy_run[i], NSV[i]);
                  hold[i] = e.res;
               end
               busy_run[i] = 0;
            end else begin
               checkOutput("hold", i, 32'(res_v[i]), 32'(hold[i]));
               if (busy_v[i]) busy_run[i]++;
            end
         end
      end
   end

   initial begin
      logic [15:0] dir_a [6] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0010};
      logic [15:0] dir_b [6] = '{16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
      logic        dir_s [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic        dir_c [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      int          pending;

      for (int i = 0; i < 3; i++) idle_edge[i] = 0;

      // Reset state.
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("reset_res", i, 32'(res_v[i]), 32'd0);
         checkOutput("reset_busy", i, 32'(busy_v[i]), 32'd0);
         checkOutput("reset_done", i, 32'(done_v[i]), 32'd0);
      end

      // Directed arithmetic cases.
      for (int n = 0; n < 6; n++) applyStimulus(dir_a[n], dir_b[n], dir_s[n], dir_c[n]);

      // start pulsed while busy: slow instances must ignore it.
      applyStimulus(16'h1234, 16'h0F0F, 1'b0, 1'b0);
      tick();
      a = 16'hAAAA; b = 16'h5555; start = 1'b1;
      tick();
      start = 1'b0;

      // start held high: back-to-back operations, new operands every edge.
      for (int n = 0; n < 20 && !allIdleNext(); n++) tick();
      start = 1'b1;
      for (int n = 0; n < 40; n++) begin
         randomOperands();
         tick();
      end
      start = 1'b0;

      // Reset two edges after a start: pending operations are abandoned.
      applyStimulus(16'h4321, 16'h1111, 1'b0, 1'b1);
      tick();
      rst = 1'b1;
      q0.delete(); q1.delete(); q2.delete();
      for (int i = 0; i < 3; i++) idle_edge[i] = 0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("abort_res", i, 32'(res_v[i]), 32'd0);
         checkOutput("abort_busy", i, 32'(busy_v[i]), 32'd0);
         checkOutput("abort_done", i, 32'(done_v[i]), 32'd0);
      end
      tick();
      applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0);

      // Random traffic with random start density.
      for (int n = 0; n < 200; n++) begin
         randomOperands();
         start = ($urandom_range(0, 2) == 0);
         tick();
      end
      start = 1'b0;

      // Drain, then every issued operation must have completed.
      for (int n = 0; n < 40 && (q0.size() + q1.size() + q2.size()) > 0; n++) tick();
      tick();
      pending = q0.size() + q1.size() + q2.size();
      checkOutput("drain_pending", 0, pending, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
